// File: rtl/amba3_apb_regbank_slave_pkg.sv
// Shared types, limits and address-check helper for the APB register-bank slave.
package pkg_amba3;

  typedef enum logic [1:0] {IDLE, WAIT, READY} amba3_apb_state_t;

  localparam int AMBA3_APB_MAX_WAIT = 15;

  // In range and word aligned; a one-byte word makes the alignment mask zero.
  function automatic logic amba3_apb_addr_ok(input logic [63:0] addr,
                                             input int depth,
                                             input int bytes);
    logic [63:0] limit;
    logic [63:0] mask;
    limit = 64'(depth) * 64'(bytes);
    mask  = 64'(bytes - 1);
    return (addr < limit) && ((addr & mask) == 64'd0);
  endfunction

endpackage

// File: rtl/amba3_apb_regbank_slave_regfile.sv
// DEPTH x DATA_SIZE register storage: synchronous reset, one write port, one combinational read port.
module amba3_apb_regfile #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/amba3_apb_regbank_slave.sv
// AMBA 3 APB slave with a DEPTH-word register bank, programmable wait states and error response.
// Define AMBA3_APB_SLVERR_EN to drive pslverr on invalid addresses; otherwise pslverr stays 0.
module amba3_apb_regbank_slave
  import pkg_amba3::*;
#(
  parameter int ADDR_SIZE   = 32,
  parameter int DATA_SIZE   = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [DATA_SIZE-1:0] pwdata,
  output logic                 pready,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 pslverr
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WS    = (WAIT_STATES > AMBA3_APB_MAX_WAIT) ? AMBA3_APB_MAX_WAIT : WAIT_STATES;
  localparam logic [3:0] WAIT_INIT = 4'((WS > 0) ? WS - 1 : 0);
`ifdef AMBA3_APB_SLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  amba3_apb_state_t     state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATA_SIZE-1:0] prdata_q, prdata_d;

  logic [ADDR_SIZE-1:0] cur_addr;
  logic                 cur_write;
  logic                 cur_ok;
  logic [IDX_W-1:0]     cur_idx;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 we;
  logic                 go_ready;
  logic                 go_idle;

  // In IDLE the setup-phase bus is live; afterwards only the latched copy counts.
  assign cur_addr  = (state_q == IDLE) ? paddr : addr_q;
  assign cur_write = (state_q == IDLE) ? pwrite : write_q;
  assign cur_ok    = amba3_apb_addr_ok(64'(cur_addr), DEPTH, BYTES);
  assign cur_idx   = cur_addr[LSB +: IDX_W];

  amba3_apb_regfile #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (we),
    .waddr (cur_idx),
    .wdata (pwdata),
    .raddr (cur_idx),
    .rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    we        = 1'b0;
    go_ready  = 1'b0;
    go_idle   = 1'b0;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          if (WS == 0) begin
            go_ready = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!psel)              go_idle  = 1'b1;
        else if (cnt_q == 4'd0) go_ready = 1'b1;
        else                    cnt_d    = cnt_q - 4'd1;
      end
      READY: begin
        if (!psel) begin
          go_idle = 1'b1;
        end else if (penable) begin
          go_idle = 1'b1;
          we      = write_q && cur_ok;
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Read data and error are captured once, on entry to READY, and held until completion.
    if (go_ready) begin
      state_d   = READY;
      pready_d  = 1'b1;
      prdata_d  = (!cur_write && cur_ok) ? rd_data : '0;
      pslverr_d = ERR_EN && !cur_ok;
    end
    if (go_idle) begin
      state_d   = IDLE;
      cnt_d     = 4'd0;
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_amba3_apb_regbank_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) on one shared APB bus, selected by psel.
module tb_amba3_apb_regbank_slave;

`ifdef AMBA3_APB_SLVERR_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif

  logic              pclk = 1'b0;
  logic              preset;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
  logic              penable;
  logic              pwrite;
  logic [2:0]        psel;
  logic [2:0]        pready;
  logic [2:0]        pslverr;
  logic [2:0][31:0]  prdata;

  always #5 pclk = ~pclk;

  amba3_apb_regbank_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  amba3_apb_regbank_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(16), .WAIT_STATES(2)) u_ws2 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  amba3_apb_regbank_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

  typedef struct {
    int          t;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_wait;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[17];

  function automatic vec_t mk(input int t, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd,
                              input logic exp_err, input int exp_wait);
    vec_t v;
    v.t = t; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_wait = exp_wait;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts the setup phase in the current cycle and returns just after the completion edge,
  // so a following call begins its setup in the very next cycle.
  task automatic xfer(input int t, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int nw);
    psel    = 3'b000;
    psel[t] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    nw = 0;
    while (!pready[t] && nw < 20) begin
      @(posedge pclk); #1;
      nw++;
    end
    rd  = prdata[t];
    err = pslverr[t];
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          nw;

    vecs[0]  = mk(0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    vecs[1]  = mk(0, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    vecs[2]  = mk(0, 1'b1, 32'h0C, 32'hA5A5A5A5, 32'h0,        1'b0, 0);
    vecs[3]  = mk(0, 1'b0, 32'h0C, 32'h0,        32'hA5A5A5A5, 1'b0, 0);
    vecs[4]  = mk(0, 1'b1, 32'h40, 32'h00001234, 32'h0,        SE,   0);
    vecs[5]  = mk(0, 1'b0, 32'h42, 32'h0,        32'h0,        SE,   0);
    vecs[6]  = mk(0, 1'b0, 32'h40, 32'h0,        32'h0,        SE,   0);
    vecs[7]  = mk(0, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0, 0);
    vecs[8]  = mk(0, 1'b1, 32'h06, 32'h00005555, 32'h0,        SE,   0);
    vecs[9]  = mk(0, 1'b0, 32'h04, 32'h0,        32'h0,        1'b0, 0);
    vecs[10] = mk(0, 1'b1, 32'h3C, 32'hCAFEF00D, 32'h0,        1'b0, 0);
    vecs[11] = mk(0, 1'b0, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0, 0);
    vecs[12] = mk(0, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    vecs[13] = mk(2, 1'b1, 32'h00, 32'h11223344, 32'h0,        1'b0, 3);
    vecs[14] = mk(2, 1'b0, 32'h00, 32'h0,        32'h11223344, 1'b0, 3);
    vecs[15] = mk(1, 1'b1, 32'h04, 32'h00000077, 32'h0,        1'b0, 2);
    vecs[16] = mk(1, 1'b0, 32'h04, 32'h0,        32'h00000077, 1'b0, 2);

    preset = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1;
    preset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_pready%0d", i),  32'(pready[i]),  32'h0);
      chk($sformatf("reset_pslverr%0d", i), 32'(pslverr[i]), 32'h0);
      chk($sformatf("reset_prdata%0d", i),  prdata[i],       32'h0);
    end

    // Reset lands on the completion edge of a write to 0x4 and is held for 3 cycles.
    psel = 3'b001; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h99; penable = 1'b0;
    @(posedge pclk); #1;
    chk("midwr_ready_before_reset", 32'(pready[0]), 32'h1);
    penable = 1'b1;
    preset  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk($sformatf("midwr_pready_c%0d", i), 32'(pready[0]), 32'h0);
    end
    preset = 1'b0; psel = 3'b000; penable = 1'b0;
    chk("midwr_prdata",  prdata[0],        32'h0);
    chk("midwr_pslverr", 32'(pslverr[0]),  32'h0);
    @(posedge pclk); #1;
    xfer(0, 1'b0, 32'h4, 32'h0, rd, err, nw);
    chk("midwr_reg1_kept_zero", rd, 32'h0);

    for (int i = 0; i < 17; i++) begin
      xfer(vecs[i].t, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, nw);
      chk($sformatf("v%0d_wait", i),    32'(nw),  32'(vecs[i].exp_wait));
      chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      if (!vecs[i].wr) chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_done_pready", i), 32'(pready[vecs[i].t]), 32'h0);
      chk($sformatf("v%0d_done_prdata", i), prdata[vecs[i].t],      32'h0);
    end

    // Abort a 2-wait-state write to 0x4 after one WAIT cycle.
    @(posedge pclk); #1;
    psel = 3'b010; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hFF; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("abort_wait1_pready", 32'(pready[1]), 32'h0);
    @(posedge pclk); #1;
    chk("abort_wait2_pready", 32'(pready[1]), 32'h0);
    psel = 3'b000; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_idle_pready",  32'(pready[1]),  32'h0);
    chk("abort_idle_pslverr", 32'(pslverr[1]), 32'h0);
    xfer(1, 1'b0, 32'h4, 32'h0, rd, err, nw);
    chk("abort_reg1_unchanged", rd,      32'h77);
    chk("abort_next_wait",      32'(nw), 32'd2);

    @(posedge pclk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amba3_apb_regbank_slave.md
# amba3_apb_regbank_slave

Parametrised AMBA 3 APB slave RTL: a bank of DEPTH word registers, programmable wait states and PSLVERR error response. It is the synthesizable counterpart to the APB bus-functional master. It sits behind an APB interconnect as a generic peripheral and as the golden DUT for the APB master's self-checks. Compared with the passive slave tasks, it adds real storage, wait-state insertion, address decoding and an error response.

## Interface
- ADDR_SIZE, 32, paddr width
- DATA_SIZE, 32, pwdata/prdata width; one of 8/16/32/64
- DEPTH, 16, number of registers; power of two, ≥2
- WAIT_STATES, 0, pready-low ACCESS cycles per transfer; 0..15
- pclk  input  1  clock, all logic on rising edge
- preset  input  1  reset; synchronous, active-high
- paddr  input  ADDR_SIZE  byte address
- psel  input  1  select
- penable  input  1  access phase
- pwrite  input  1  1 = write
- pwdata  input  DATA_SIZE  write data
- pready  output  1  transfer complete (registered)
- prdata  output  DATA_SIZE  read data (registered)
- pslverr  output  1  error response (registered)

## Operation
- BYTES = DATA_SIZE/8, LSB = log2(BYTES), idx = paddr[LSB +: log2(DEPTH)].
- Address valid when paddr < DEPTH*BYTES and paddr[LSB-1:0] == 0 (misaligned = invalid; no alignment check when DATA_SIZE = 8).
- FSM states:
  - IDLE → WAIT (WAIT_STATES > 0, cnt <= WAIT_STATES-1) or READY (WAIT_STATES = 0), on an edge sampling psel & !penable.
  - WAIT: cnt decrements each edge; at cnt == 0 → READY.
  - READY: pready = 1. At the edge sampling psel & penable → IDLE, transfer completes.
- On entry to READY:
  - Read with valid address: prdata <= reg[idx].
  - Invalid address: prdata <= 0.
  - pslverr <= !valid (see Configuration).
- Write commits at the completion edge: reg[idx] <= pwdata, only if the address is valid.
- On return to IDLE: pready, pslverr and prdata are cleared to 0.
- Abort: psel low in WAIT or READY → IDLE, no register write, outputs cleared.
- paddr and pwrite are latched at the setup edge. Changes during ACCESS are ignored.

## Timing
- Reset (preset high at an edge):
  - state IDLE, cnt 0, pready 0, prdata 0, pslverr 0, all registers 0.
  - Reset mid-transfer drops the transfer; no write.
- Transfer length is setup + (WAIT_STATES + 1) access cycles.
- WAIT_STATES = 0: pready is high in the first ACCESS cycle.
- Back-to-back: a new SETUP may occur in the cycle after completion. The next transfer sees the previous write (read-after-write coherent).
- prdata and pslverr are valid only while pready = 1.

## Configuration
- AMBA3_APB_SLVERR_EN
  - Defined: pslverr is asserted with pready for invalid addresses.
  - Undefined: pslverr is tied to 0. Invalid writes are silently dropped; invalid reads return 0.

## Structure
- Package pkg_amba3 holds:
  - typedef enum logic [1:0] amba3_apb_state_t {IDLE, WAIT, READY}
  - constant AMBA3_APB_MAX_WAIT = 15
  - function amba3_apb_addr_ok(addr, depth, bytes)
- One sub-module, amba3_apb_regfile: DEPTH×DATA_SIZE storage with synchronous reset, one write port and one combinational read port.
- The top level keeps the FSM, wait counter, address decode and output registers.

## Test plan
- Reset: assert preset 3 cycles mid-write to 0x4 → pready/prdata/pslverr 0, reg[1] stays 0.
- WAIT_STATES=0: write 0x8 = 0xDEADBEEF, then read 0x8 → pready high in first access cycle, prdata 0xDEADBEEF, pslverr 0.
- WAIT_STATES=3: read 0x0 → exactly 3 access cycles with pready low, completion on the 4th.
- Out of range, DEPTH=16, 32-bit: write 0x40 = 0x1234 and read 0x42:
  - With AMBA3_APB_SLVERR_EN: pslverr 1 on both.
  - Without: pslverr 0, prdata 0.
  - In both builds, no register changes.
- Back-to-back: write 0xC = 0xA5A5A5A5 with the read of 0xC starting the next cycle → read returns 0xA5A5A5A5.
- Abort: WAIT_STATES=2, psel dropped after one WAIT cycle of a write to 0x4 = 0xFF → reg[1] unchanged, FSM in IDLE the next cycle.
